// File: rtl/hoplite_mmio_net_iface.sv
// rtl/hoplite_mmio_net_iface.sv - MMIO staging/TX FIFO/RX FIFO bridge between picorv32 and a Hoplite port
// Optional perf counters: define NI_PERF_COUNTERS_EN.
`timescale 1ns/1ps
module hoplite_mmio_net_iface #(
    parameter int          COORD_BITS           = 1,
    parameter int          MULTICAST_GROUP_BITS = 1,
    parameter int          MATRIX_TYPE_BITS     = 1,
    parameter int          MATRIX_COORD_BITS    = 8,
    parameter int          MATRIX_ELEMENT_BITS  = 32,
    parameter int          TX_FIFO_DEPTH        = 4,
    parameter int          RX_FIFO_DEPTH        = 4,
    parameter logic [31:0] BASE_ADDR            = 32'h1000_0000,
    localparam int         PACKET_BITS          = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 +
                                                  MATRIX_TYPE_BITS + 2*MATRIX_COORD_BITS +
                                                  MATRIX_ELEMENT_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bus_write,
    input  logic                   bus_read,
    input  logic [31:0]            bus_addr,
    input  logic [31:0]            bus_wdata,
    output logic [31:0]            bus_rdata,
    output logic                   bus_rdata_hit,
    output logic [PACKET_BITS-1:0] packet_out,
    output logic                   packet_out_valid,
    input  logic                   packet_out_ready,
    input  logic [PACKET_BITS-1:0] packet_in,
    input  logic                   packet_in_valid,
    output logic                   packet_in_ready
);

    localparam int TX_AW = $clog2(TX_FIFO_DEPTH);
    localparam int RX_AW = $clog2(RX_FIFO_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_CW = RX_AW + 1;

    localparam int E_LSB    = 0;
    localparam int MY_LSB   = E_LSB + MATRIX_ELEMENT_BITS;
    localparam int MX_LSB   = MY_LSB + MATRIX_COORD_BITS;
    localparam int MT_LSB   = MX_LSB + MATRIX_COORD_BITS;
    localparam int RES_LSB  = MT_LSB + MATRIX_TYPE_BITS;
    localparam int DONE_LSB = RES_LSB + 1;
    localparam int MC_LSB   = DONE_LSB + 1;
    localparam int Y_LSB    = MC_LSB + MULTICAST_GROUP_BITS;
    localparam int X_LSB    = Y_LSB + COORD_BITS;

    localparam logic [7:0] OFF_X       = 8'h00;
    localparam logic [7:0] OFF_Y       = 8'h04;
    localparam logic [7:0] OFF_MC      = 8'h08;
    localparam logic [7:0] OFF_DONE    = 8'h0C;
    localparam logic [7:0] OFF_RES     = 8'h10;
    localparam logic [7:0] OFF_MT      = 8'h14;
    localparam logic [7:0] OFF_MX      = 8'h18;
    localparam logic [7:0] OFF_MY      = 8'h1C;
    localparam logic [7:0] OFF_EL      = 8'h20;
    localparam logic [7:0] OFF_COMMIT  = 8'h24;
    localparam logic [7:0] OFF_STATUS  = 8'h28;
    localparam logic [7:0] OFF_RX_POP  = 8'h2C;
    localparam logic [7:0] OFF_TX_SENT = 8'h30;
    localparam logic [7:0] OFF_RX_RECV = 8'h34;
    localparam logic [7:0] OFF_TX_STL  = 8'h38;
    localparam logic [7:0] RX_BASE     = 8'h40;

    // Address decode: the subtraction wraps, so anything below BASE_ADDR lands far outside the window.
    logic [31:0] offset;
    logic        in_win;
    logic [7:0]  reg_off;
    logic        wr_en;
    logic        rd_en;

    assign offset  = bus_addr - BASE_ADDR;
    assign in_win  = (offset[31:8] == 24'd0) && (offset[1:0] == 2'b00);
    assign reg_off = offset[7:0];
    assign wr_en   = bus_write && in_win;
    assign rd_en   = bus_read && in_win;

    logic wr_commit;
    logic wr_status;
    logic wr_rx_pop;

    assign wr_commit = wr_en && (reg_off == OFF_COMMIT);
    assign wr_status = wr_en && (reg_off == OFF_STATUS);
    assign wr_rx_pop = wr_en && (reg_off == OFF_RX_POP);

    logic [COORD_BITS-1:0]           stg_x_q;
    logic [COORD_BITS-1:0]           stg_y_q;
    logic [MULTICAST_GROUP_BITS-1:0] stg_mc_q;
    logic                            stg_done_q;
    logic                            stg_res_q;
    logic [MATRIX_TYPE_BITS-1:0]     stg_mt_q;
    logic [MATRIX_COORD_BITS-1:0]    stg_mx_q;
    logic [MATRIX_COORD_BITS-1:0]    stg_my_q;
    logic [MATRIX_ELEMENT_BITS-1:0]  stg_el_q;
    logic [PACKET_BITS-1:0]          stg_pkt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_x_q    <= '0;
            stg_y_q    <= '0;
            stg_mc_q   <= '0;
            stg_done_q <= 1'b0;
            stg_res_q  <= 1'b0;
            stg_mt_q   <= '0;
            stg_mx_q   <= '0;
            stg_my_q   <= '0;
            stg_el_q   <= '0;
        end else if (wr_en) begin
            case (reg_off)
                OFF_X:    stg_x_q    <= bus_wdata[COORD_BITS-1:0];
                OFF_Y:    stg_y_q    <= bus_wdata[COORD_BITS-1:0];
                OFF_MC:   stg_mc_q   <= bus_wdata[MULTICAST_GROUP_BITS-1:0];
                OFF_DONE: stg_done_q <= bus_wdata[0];
                OFF_RES:  stg_res_q  <= bus_wdata[0];
                OFF_MT:   stg_mt_q   <= bus_wdata[MATRIX_TYPE_BITS-1:0];
                OFF_MX:   stg_mx_q   <= bus_wdata[MATRIX_COORD_BITS-1:0];
                OFF_MY:   stg_my_q   <= bus_wdata[MATRIX_COORD_BITS-1:0];
                OFF_EL:   stg_el_q   <= bus_wdata[MATRIX_ELEMENT_BITS-1:0];
                default: ;
            endcase
        end
    end

    assign stg_pkt = {stg_x_q, stg_y_q, stg_mc_q, stg_done_q, stg_res_q,
                      stg_mt_q, stg_mx_q, stg_my_q, stg_el_q};

    // TX FIFO
    logic [PACKET_BITS-1:0] tx_mem_q [TX_FIFO_DEPTH];
    logic [TX_AW-1:0]       tx_wr_ptr_q, tx_wr_ptr_d;
    logic [TX_AW-1:0]       tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TX_CW-1:0]       tx_count_q, tx_count_d;
    logic                   tx_full;
    logic                   tx_deq;
    logic                   tx_push;

    assign tx_full          = (tx_count_q == TX_CW'(TX_FIFO_DEPTH));
    assign packet_out_valid = (tx_count_q != '0);
    assign packet_out       = tx_mem_q[tx_rd_ptr_q];
    assign tx_deq           = packet_out_valid && packet_out_ready;
    // A full FIFO still accepts a commit when the head leaves in the same cycle.
    assign tx_push          = wr_commit && (!tx_full || tx_deq);

    always_comb begin
        tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + TX_AW'(1) : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_deq  ? tx_rd_ptr_q + TX_AW'(1) : tx_rd_ptr_q;
        tx_count_d  = tx_count_q;
        case ({tx_push, tx_deq})
            2'b10:   tx_count_d = tx_count_q + TX_CW'(1);
            2'b01:   tx_count_d = tx_count_q - TX_CW'(1);
            default: tx_count_d = tx_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= stg_pkt;
        end
    end

    // RX FIFO
    logic [PACKET_BITS-1:0] rx_mem_q [RX_FIFO_DEPTH];
    logic [RX_AW-1:0]       rx_wr_ptr_q, rx_wr_ptr_d;
    logic [RX_AW-1:0]       rx_rd_ptr_q, rx_rd_ptr_d;
    logic [RX_CW-1:0]       rx_count_q, rx_count_d;
    logic                   rx_full;
    logic                   rx_empty;
    logic                   rx_pop;
    logic                   rx_push;
    logic [PACKET_BITS-1:0] rx_head;

    assign rx_full         = (rx_count_q == RX_CW'(RX_FIFO_DEPTH));
    assign rx_empty        = (rx_count_q == '0);
    assign rx_pop          = wr_rx_pop && !rx_empty;
    // A pop frees a slot this cycle, so a full RX FIFO can take a packet alongside it.
    assign packet_in_ready = !rx_full || rx_pop;
    assign rx_push         = packet_in_valid && packet_in_ready;
    assign rx_head         = rx_mem_q[rx_rd_ptr_q];

    always_comb begin
        rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + RX_AW'(1) : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + RX_AW'(1) : rx_rd_ptr_q;
        rx_count_d  = rx_count_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + RX_CW'(1);
            2'b01:   rx_count_d = rx_count_q - RX_CW'(1);
            default: rx_count_d = rx_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= packet_in;
        end
    end

    logic tx_ovf_q, tx_ovf_d;
    logic rx_unf_q, rx_unf_d;

    always_comb begin
        tx_ovf_d = tx_ovf_q || (wr_commit && !tx_push);
        rx_unf_d = rx_unf_q || (wr_rx_pop && rx_empty);
        if (wr_status) begin
            tx_ovf_d = 1'b0;
            rx_unf_d = 1'b0;
        end
    end

`ifdef NI_PERF_COUNTERS_EN
    logic [31:0] perf_tx_sent_q;
    logic [31:0] perf_rx_recv_q;
    logic [31:0] perf_tx_stall_q;
    logic        perf_clr;

    assign perf_clr = wr_en && (reg_off == OFF_TX_SENT);

    always_ff @(posedge clk) begin
        if (reset || perf_clr) begin
            perf_tx_sent_q  <= '0;
            perf_rx_recv_q  <= '0;
            perf_tx_stall_q <= '0;
        end else begin
            if (tx_deq)                                perf_tx_sent_q  <= perf_tx_sent_q + 32'd1;
            if (rx_push)                               perf_rx_recv_q  <= perf_rx_recv_q + 32'd1;
            if (packet_out_valid && !packet_out_ready) perf_tx_stall_q <= perf_tx_stall_q + 32'd1;
        end
    end
`endif

    logic [31:0] status_word;
    logic [31:0] rd_val;
    logic [31:0] bus_rdata_q, bus_rdata_d;
    logic        bus_rdata_hit_q, bus_rdata_hit_d;

    assign status_word = {8'h00, 8'(rx_count_q), 8'(tx_count_q), 4'h0,
                          rx_unf_q, tx_ovf_q, !rx_empty, !tx_full};

    always_comb begin
        rd_val = '0;
        case (reg_off)
            OFF_STATUS:     rd_val = status_word;
`ifdef NI_PERF_COUNTERS_EN
            OFF_TX_SENT:    rd_val = perf_tx_sent_q;
            OFF_RX_RECV:    rd_val = perf_rx_recv_q;
            OFF_TX_STL:     rd_val = perf_tx_stall_q;
`endif
            RX_BASE + OFF_X:    if (!rx_empty) rd_val = 32'(rx_head[X_LSB +: COORD_BITS]);
            RX_BASE + OFF_Y:    if (!rx_empty) rd_val = 32'(rx_head[Y_LSB +: COORD_BITS]);
            RX_BASE + OFF_MC:   if (!rx_empty) rd_val = 32'(rx_head[MC_LSB +: MULTICAST_GROUP_BITS]);
            RX_BASE + OFF_DONE: if (!rx_empty) rd_val = 32'(rx_head[DONE_LSB]);
            RX_BASE + OFF_RES:  if (!rx_empty) rd_val = 32'(rx_head[RES_LSB]);
            RX_BASE + OFF_MT:   if (!rx_empty) rd_val = 32'(rx_head[MT_LSB +: MATRIX_TYPE_BITS]);
            RX_BASE + OFF_MX:   if (!rx_empty) rd_val = 32'(rx_head[MX_LSB +: MATRIX_COORD_BITS]);
            RX_BASE + OFF_MY:   if (!rx_empty) rd_val = 32'(rx_head[MY_LSB +: MATRIX_COORD_BITS]);
            RX_BASE + OFF_EL:   if (!rx_empty) rd_val = 32'(rx_head[E_LSB +: MATRIX_ELEMENT_BITS]);
            default:        rd_val = '0;
        endcase
    end

    always_comb begin
        bus_rdata_d     = rd_en ? rd_val : bus_rdata_q;
        bus_rdata_hit_d = rd_en;
    end

    assign bus_rdata     = bus_rdata_q;
    assign bus_rdata_hit = bus_rdata_hit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr_q     <= '0;
            tx_rd_ptr_q     <= '0;
            tx_count_q      <= '0;
            rx_wr_ptr_q     <= '0;
            rx_rd_ptr_q     <= '0;
            rx_count_q      <= '0;
            tx_ovf_q        <= 1'b0;
            rx_unf_q        <= 1'b0;
            bus_rdata_q     <= '0;
            bus_rdata_hit_q <= 1'b0;
        end else begin
            tx_wr_ptr_q     <= tx_wr_ptr_d;
            tx_rd_ptr_q     <= tx_rd_ptr_d;
            tx_count_q      <= tx_count_d;
            rx_wr_ptr_q     <= rx_wr_ptr_d;
            rx_rd_ptr_q     <= rx_rd_ptr_d;
            rx_count_q      <= rx_count_d;
            tx_ovf_q        <= tx_ovf_d;
            rx_unf_q        <= rx_unf_d;
            bus_rdata_q     <= bus_rdata_d;
            bus_rdata_hit_q <= bus_rdata_hit_d;
        end
    end

endmodule

// File: tb/tb_hoplite_mmio_net_iface.sv
// tb/tb_hoplite_mmio_net_iface.sv - scoreboard bench for hoplite_mmio_net_iface
`timescale 1ns/1ps
module tb_hoplite_mmio_net_iface;

    localparam int          PB   = 54;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          bus_write;
    logic          bus_read;
    logic [31:0]   bus_addr;
    logic [31:0]   bus_wdata;
    logic [31:0]   bus_rdata;
    logic          bus_rdata_hit;
    logic [PB-1:0] packet_out;
    logic          packet_out_valid;
    logic          packet_out_ready;
    logic [PB-1:0] packet_in;
    logic          packet_in_valid;
    logic          packet_in_ready;

    hoplite_mmio_net_iface dut (
        .clk              (clk),
        .reset            (reset),
        .bus_write        (bus_write),
        .bus_read         (bus_read),
        .bus_addr         (bus_addr),
        .bus_wdata        (bus_wdata),
        .bus_rdata        (bus_rdata),
        .bus_rdata_hit    (bus_rdata_hit),
        .packet_out       (packet_out),
        .packet_out_valid (packet_out_valid),
        .packet_out_ready (packet_out_ready),
        .packet_in        (packet_in),
        .packet_in_valid  (packet_in_valid),
        .packet_in_ready  (packet_in_ready)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int deq_count = 0;

    logic [31:0]   rd_exp_q [$];
    string         rd_name_q [$];
    logic [PB-1:0] tx_exp_q [$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [PB-1:0] mktx(input logic x, input logic [31:0] el);
        return {x, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, el};
    endfunction

    function automatic logic [PB-1:0] mkrx(input logic [31:0] el);
        return {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h12, 8'h34, el};
    endfunction

    always @(negedge clk) begin
        if (bus_rdata_hit) begin
            if (rd_exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read_hit actual=%h required=no_hit", bus_rdata);
            end else begin
                check(rd_name_q.pop_front(), {32'h0, bus_rdata}, {32'h0, rd_exp_q.pop_front()});
            end
        end
        if (packet_out_valid && packet_out_ready && !reset) begin
            deq_count++;
            if (tx_exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tx actual=%h required=none", packet_out);
            end else begin
                check("tx_packet", {10'h0, packet_out}, {10'h0, tx_exp_q.pop_front()});
            end
        end
    end

    task automatic wr_abs(input logic [31:0] a, input logic [31:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_write = 1'b1;
        @(posedge clk);
        #1;
        bus_write = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        wr_abs(BASE + {24'h0, off}, d);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] e, input string nm);
        rd_exp_q.push_back(e);
        rd_name_q.push_back(nm);
        bus_addr = BASE + {24'h0, off};
        bus_read = 1'b1;
        @(posedge clk);
        #1;
        bus_read = 1'b0;
    endtask

    task automatic rd_miss(input logic [31:0] a, input logic [31:0] held, input string nm);
        bus_addr = a;
        bus_read = 1'b1;
        @(posedge clk);
        #1;
        bus_read = 1'b0;
        check({nm, "_hit"}, {63'h0, bus_rdata_hit}, 64'h0);
        check({nm, "_held"}, {32'h0, bus_rdata}, {32'h0, held});
    endtask

    task automatic commit_el(input logic [31:0] el, input logic x, input logic expect_out);
        wr(8'h20, el);
        wr(8'h24, 32'h0);
        if (expect_out) tx_exp_q.push_back(mktx(x, el));
    endtask

    task automatic rx_send(input logic [31:0] el);
        packet_in       = mkrx(el);
        packet_in_valid = 1'b1;
        @(posedge clk);
        #1;
        packet_in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset            = 1'b1;
        bus_write        = 1'b0;
        bus_read         = 1'b0;
        bus_addr         = '0;
        bus_wdata        = '0;
        packet_out_ready = 1'b0;
        packet_in        = '0;
        packet_in_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_out_valid", {63'h0, packet_out_valid}, 64'h0);
        check("reset_in_ready", {63'h0, packet_in_ready}, 64'h1);
        check("reset_rdata", {32'h0, bus_rdata}, 64'h0);
        check("reset_rdata_hit", {63'h0, bus_rdata_hit}, 64'h0);
        rd(8'h28, 32'h0000_0001, "reset_status");

        // Single packet straight through
        packet_out_ready = 1'b1;
        wr(8'h00, 32'h1);
        tx_exp_q.push_back(54'h20_0000_DEAD_BEEF);
        wr(8'h20, 32'hDEAD_BEEF);
        wr(8'h24, 32'h0);
        check("t1_valid", {63'h0, packet_out_valid}, 64'h1);
        @(posedge clk);
        #1;
        check("t1_valid_one_cycle", {63'h0, packet_out_valid}, 64'h0);
        rd(8'h28, 32'h0000_0001, "t1_status");

        // Out-of-window and unaligned accesses do nothing
        wr_abs(BASE + 32'h124, 32'h0);
        wr_abs(BASE - 32'h4, 32'h0);
        wr_abs(BASE + 32'h25, 32'h0);
        rd_miss(BASE + 32'h100, 32'h1, "oow_read");
        rd_miss(BASE + 32'h29, 32'h1, "unaligned_read");
        rd(8'h28, 32'h0000_0001, "oow_status");

        // TX overflow with ready held low
        packet_out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) commit_el(i, 1'b1, i <= 4);
        rd(8'h28, 32'h0000_0404, "t2_status_full");
        d0 = deq_count;
        packet_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t2_deq_consecutive", 64'(deq_count - d0), 64'd4);
        check("t2_valid_drained", {63'h0, packet_out_valid}, 64'h0);
        wr(8'h28, 32'h0);
        rd(8'h28, 32'h0000_0001, "t2_status_cleared");

        // RX fill, field reads, pop, simultaneous push/pop when full
        for (int i = 10; i <= 13; i++) rx_send(i);
        check("t3_in_ready_full", {63'h0, packet_in_ready}, 64'h0);
        rd(8'h28, 32'h0004_0003, "t3_status_full");
        rd(8'h60, 32'd10, "t3_head_el");
        check("t3_rd_latency", {63'h0, bus_rdata_hit}, 64'h1);
        rd(8'h58, 32'h12, "t3_head_mx");
        rd(8'h5C, 32'h34, "t3_head_my");
        rd(8'h44, 32'h1, "t3_head_y");
        rd(8'h40, 32'h0, "t3_head_x");
        rd(8'h60, 32'd10, "t3_read_no_pop");
        wr(8'h2C, 32'h0);
        rd(8'h60, 32'd11, "t3_after_pop");
        rx_send(14);
        check("t3_in_ready_refull", {63'h0, packet_in_ready}, 64'h0);
        packet_in       = mkrx(15);
        packet_in_valid = 1'b1;
        bus_addr        = BASE + 32'h2C;
        bus_write       = 1'b1;
        #1;
        check("t3_in_ready_with_pop", {63'h0, packet_in_ready}, 64'h1);
        @(posedge clk);
        #1;
        bus_write       = 1'b0;
        packet_in_valid = 1'b0;
        rd(8'h28, 32'h0004_0003, "t3_status_pushpop");
        for (int i = 12; i <= 15; i++) begin
            rd(8'h60, i, "t3_drain_order");
            wr(8'h2C, 32'h0);
        end

        // RX underflow
        rd(8'h28, 32'h0000_0001, "t4_status_empty");
        wr(8'h2C, 32'h0);
        rd(8'h28, 32'h0000_0009, "t4_status_underflow");
        rd(8'h40, 32'h0, "t4_empty_x");
        rd(8'h60, 32'h0, "t4_empty_el");
        wr(8'h28, 32'h0);

        // Commit into a full TX FIFO while the head leaves
        packet_out_ready = 1'b0;
        for (int i = 21; i <= 24; i++) commit_el(i, 1'b1, 1'b1);
        wr(8'h20, 32'd25);
        tx_exp_q.push_back(mktx(1'b1, 32'd25));
        packet_out_ready = 1'b1;
        bus_addr         = BASE + 32'h24;
        bus_write        = 1'b1;
        @(posedge clk);
        #1;
        bus_write        = 1'b0;
        packet_out_ready = 1'b0;
        rd(8'h28, 32'h0000_0400, "t5_status_full_no_ovf");

        // Reset mid-stream discards queued packets and staging
        pulse_reset();
        check("t5_reset_out_valid", {63'h0, packet_out_valid}, 64'h0);
        check("t5_reset_in_ready", {63'h0, packet_in_ready}, 64'h1);
        tx_exp_q.delete();
        rd(8'h28, 32'h0000_0001, "t5_status_after_reset");
        tx_exp_q.push_back(mktx(1'b0, 32'h0));
        wr(8'h24, 32'h0);
        packet_out_ready = 1'b1;
        @(posedge clk);
        #1;
        packet_out_ready = 1'b0;
        pulse_reset();

        // Performance counters: 3 packets, 2 stall cycles, 1 RX packet
        commit_el(31, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        packet_out_ready = 1'b1;
        commit_el(32, 1'b0, 1'b1);
        commit_el(33, 1'b0, 1'b1);
        rx_send(40);
        @(posedge clk);
        #1;
`ifdef NI_PERF_COUNTERS_EN
        rd(8'h30, 32'd3, "t6_tx_sent");
        rd(8'h34, 32'd1, "t6_rx_recv");
        rd(8'h38, 32'd2, "t6_tx_stall");
`else
        rd(8'h30, 32'd0, "t6_tx_sent_absent");
        rd(8'h34, 32'd0, "t6_rx_recv_absent");
        rd(8'h38, 32'd0, "t6_tx_stall_absent");
`endif
        wr(8'h30, 32'h0);
        rd(8'h30, 32'd0, "t6_tx_sent_clr");
        rd(8'h34, 32'd0, "t6_rx_recv_clr");
        rd(8'h38, 32'd0, "t6_tx_stall_clr");
        rd(8'h28, 32'h0001_0003, "t6_status");

        repeat (3) @(posedge clk);
        #1;
        check("rd_queue_drained", 64'(rd_exp_q.size()), 64'd0);
        check("tx_queue_drained", 64'(tx_exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
